// File: rtl/jtcps1_watch_pkg.sv
// Shared definitions for the video-bus watch scheduler: run-sequencer
// states and the default geometry of the watch block.
package jtcps1_watch_pkg;

   localparam int unsigned W_DEF      = 14;  // watched signal lines
   localparam int unsigned CW_DEF     = 16;  // event counter width
   localparam int unsigned FRAMES_DEF = 4;   // frames per single-mode run

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARM   = 2'd1,
      ST_COUNT = 2'd2,
      ST_LATCH = 2'd3
   } state_t;

endpackage

// File: rtl/jtcps1_watch_cnt.sv
// Rising-edge detector on the selected watch line, sampled only on pixel
// clock enables, feeding a saturating event counter.
module jtcps1_watch_cnt #(
   parameter int unsigned CW = 16
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          pxl_cen,
   input  logic          line,
   input  logic          clr,
   input  logic          en,
   output logic [CW-1:0] count
);

   logic line_d;
   logic rise;

   assign rise = pxl_cen & line & ~line_d;

   // Previous pxl_cen sample of the selected line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       line_d <= 1'b0;
      else if (pxl_cen) line_d <= line;
   end

   // Event counter: clear on frame start, count edges, stick at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                           count <= '0;
      else if (clr)                         count <= '0;
      else if (en && rise && count != '1)   count <= count + 1'b1;
   end

endmodule

// File: rtl/jtcps1_watch_sched.sv
// Watch scheduler: counts rising edges of one selected video-bus line over
// whole frames (VB fall to VB rise) and reports one result per frame.
// Optional build macro: JTCPS1_WATCH_AUTO_EN -- rotate the selected line by
// one after every measured frame that continues the run.
module jtcps1_watch_sched
   import jtcps1_watch_pkg::*;
#(
   parameter int unsigned W      = W_DEF,
   parameter int unsigned CW     = CW_DEF,
   parameter int unsigned FRAMES = FRAMES_DEF
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          pxl_cen,
   input  logic          VB,
   input  logic [W-1:0]  sig_in,
   input  logic [3:0]    sel,
   input  logic          start,
   input  logic          cont,
   output logic [CW-1:0] result,
   output logic [3:0]    res_line,
   output logic          res_valid,
   output logic          busy,
   output logic          watch
);

   localparam int unsigned FLW = (FRAMES > 1) ? $clog2(FRAMES) : 1;

   state_t          state, state_nx;
   logic [3:0]      sel_r;
   logic [FLW-1:0]  frames_left;
   logic            vb_d;
   logic            vb_fall, vb_rise;
   logic            sel_line;
   logic            cnt_clr, cnt_en;
   logic            go_on;
   logic [CW-1:0]   count;

   assign vb_fall = pxl_cen &  vb_d & ~VB;
   assign vb_rise = pxl_cen & ~vb_d &  VB;
   assign go_on   = cont | (frames_left != '0);
   assign busy    = (state != ST_IDLE);

   // Line mux; out-of-range selects read as a constant 0.
   always_comb begin
      sel_line = 1'b0;
      for (int unsigned i = 0; i < W; i++)
         if (32'(sel_r) == i) sel_line = sig_in[i];
   end

   // VB history, sampled on pixel enables only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       vb_d <= 1'b0;
      else if (pxl_cen) vb_d <= VB;
   end

   // Sequencer state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nx;
   end

   // Sequencer next state and counter controls.
   always_comb begin
      state_nx = state;
      cnt_clr  = 1'b0;
      cnt_en   = 1'b0;
      unique case (state)
         ST_IDLE:  if (start) state_nx = ST_ARM;
         ST_ARM:   if (vb_fall) begin
                      state_nx = ST_COUNT;
                      cnt_clr  = 1'b1;
                   end
         ST_COUNT: begin
                      cnt_en = 1'b1;
                      if (vb_rise) state_nx = ST_LATCH;
                   end
         ST_LATCH: state_nx = go_on ? ST_ARM : ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   // Run setup and per-frame bookkeeping: line select and frames remaining.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_r       <= '0;
         frames_left <= '0;
      end else if (state == ST_IDLE && start) begin
         sel_r       <= sel;
         frames_left <= FLW'(FRAMES - 1);
      end else if (state == ST_LATCH && go_on) begin
         if (frames_left != '0) frames_left <= frames_left - 1'b1;
`ifdef JTCPS1_WATCH_AUTO_EN
         sel_r <= (32'(sel_r) >= W - 1) ? '0 : sel_r + 4'd1;
`endif
      end
   end

   // Result latch; strobe follows the latch cycle by one clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result    <= '0;
         res_line  <= '0;
         res_valid <= 1'b0;
      end else begin
         res_valid <= (state == ST_LATCH);
         if (state == ST_LATCH) begin
            result   <= count;
            res_line <= sel_r;
         end
      end
   end

   // Debug copy of the selected line, independent of the sequencer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) watch <= 1'b0;
      else        watch <= sel_line;
   end

   jtcps1_watch_cnt #(.CW(CW)) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .pxl_cen (pxl_cen),
      .line    (sel_line),
      .clr     (cnt_clr),
      .en      (cnt_en),
      .count   (count)
   );

endmodule

// File: doc/jtcps1_watch_sched.md
JTCPS1_WATCH_SCHED -- requirements
Module: jtcps1_watch_sched

Interface
REQ-001 Parameter W, 14: number of watched signal lines.
REQ-002 Parameter CW, 16: event counter width.
REQ-003 Parameter FRAMES, 4: frames measured per run in single mode.
REQ-004 clk  in  1  system clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 pxl_cen  in  1  pixel clock enable; event sampling occurs only on cycles where it is high.
REQ-007 VB  in  1  vertical blank; frame boundaries are detected from it.
REQ-008 sig_in  in  W  raw watch lines (scroll, palette, row, object, VRAM, DMA, raster, chip selects).
REQ-009 sel  in  4  manual line select; values >= W select nothing.
REQ-010 start  in  1  run request pulse; ignored unless FSM is IDLE.
REQ-011 cont  in  1  continuous mode; run never ends while high.
REQ-012 result  out  CW  last latched frame count.
REQ-013 res_line  out  4  line index that result belongs to.
REQ-014 res_valid  out  1  one-cycle strobe when result updates.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 watch  out  1  registered copy of the selected line, for LED/debug output.

Function
REQ-017 FSM states SHALL be IDLE, ARM, COUNT, LATCH.
REQ-018 IDLE->ARM on start; sel_r captures sel and frames_left loads FRAMES-1 on the same edge.
REQ-019 ARM->COUNT on the first pxl_cen cycle where VB falls (VB_d=1, VB=0); counter clears to 0 on that transition.
REQ-020 In COUNT, each pxl_cen cycle where sig_in[sel_r] rises (0 in the previous pxl_cen sample, 1 now) SHALL add 1 to the counter.
REQ-021 The counter SHALL saturate at all-ones and never wrap.
REQ-022 COUNT->LATCH on the pxl_cen cycle where VB rises; an event on that same cycle SHALL be counted.
REQ-023 LATCH SHALL last exactly one clk. In it: result<=counter, res_line<=sel_r, res_valid=1 on the following cycle.
REQ-024 LATCH->ARM if cont=1 or frames_left!=0, decrementing frames_left when nonzero; otherwise LATCH->IDLE.
REQ-025 When sel_r>=W, the selected line SHALL read as 0 and result SHALL be 0.
REQ-026 start while busy SHALL be ignored, and sel changes while busy SHALL not affect sel_r.
REQ-027 watch SHALL equal sig_in[sel_r] registered one clk, independent of FSM state; it is 0 when sel_r>=W.
REQ-028 Latency: result is valid 2 clk after the VB-rise pxl_cen cycle.

Reset
REQ-029 While rst_n=0: FSM=IDLE; counter, result, res_line, sel_r, frames_left=0; res_valid, busy, watch=0; edge-detect registers=0.
REQ-030 Reset asserted mid-run SHALL abort without issuing res_valid; the first cycle after release is IDLE.

Configuration
REQ-031 With JTCPS1_WATCH_AUTO_EN defined, each LATCH->ARM transition SHALL advance sel_r by 1, wrapping from W-1 to 0, so successive frames scan all lines; res_line reports the line just measured.
REQ-032 Without JTCPS1_WATCH_AUTO_EN, sel_r stays fixed for the whole run, and no rotation logic SHALL be synthesised.

Structure
REQ-033 The FSM state enum and the default constants for W, CW and FRAMES SHALL live in a shared package, jtcps1_watch_pkg.
REQ-034 One sub-module, jtcps1_watch_cnt, SHALL hold the pxl_cen-gated edge detector and the saturating counter. The top level holds the FSM, select and latch logic.

Verification
REQ-035 Scenario 1: sel=3, start, single mode, 5 pulses on sig_in[3] per frame -> 4 res_valid strobes with result=5 and res_line=3, then busy=0.
REQ-036 Scenario 2: continuous-high sig_in[0] across a frame -> result=1 (edges only, not levels).
REQ-037 Scenario 3: CW=4, 20 pulses in one frame -> result=15 (saturated).
REQ-038 Scenario 4: rst_n pulsed low mid-COUNT -> all outputs 0, FSM in IDLE, no res_valid.
REQ-039 Scenario 5: with JTCPS1_WATCH_AUTO_EN, cont=1, sel=12, W=14 -> res_line sequence 12,13,0,1.
REQ-040 Scenario 6: sel=15 -> result=0 and watch=0 every frame; start asserted while busy -> no restart, frames_left unchanged.
